stream_arbiter: RTL and testbench



---
 rtl/stream_arbiter.sv | 109 ++++++++++
 tb/tb_stream_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// stream_arbiter: per-master packet arbiter producing the crossbar grant matrix and routing handshakes
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin per master; otherwise fixed priority, lowest index wins)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid_i, s_last_i   per-source beat valid / last beat of packet
//   s_dest_i              per-source destination, slice j belongs to source j
//   s_ready_o             per-source ready, routed from the granted master
//   m_ready_i             per-master ready
//   m_valid_o, m_last_o   per-master valid / last, routed from the granted source
//   m_id_o                granted source index per master
//   grant_o               bit i*S_DATA_COUNT+j set when master i is granted to source j
module stream_arbiter #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [S_DATA_COUNT-1:0]            s_valid_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]            s_last_i,
  output logic [S_DATA_COUNT-1:0]            s_ready_o,
  input  logic [M_DATA_COUNT-1:0]            m_ready_i,
  output logic [M_DATA_COUNT-1:0]            m_valid_o,
  output logic [M_DATA_COUNT-1:0]            m_last_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q [M_DATA_COUNT];
  state_t state_d [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_q, grant_d, req;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] id_q, id_d, win;
`ifdef ARB_ROUND_ROBIN_EN
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] ptr_q, ptr_d;
`endif
  logic [S_DATA_COUNT-1:0] src_busy;
  logic [M_DATA_COUNT-1:0] done;
  assign grant_o = grant_q;
  assign m_id_o  = id_q;
  always_comb begin
    src_busy  = '0;
    s_ready_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      src_busy  = src_busy | grant_q[i];
      s_ready_o = s_ready_o | (grant_q[i] & {S_DATA_COUNT{m_ready_i[i]}});
      m_valid_o[i] = |(grant_q[i] & s_valid_i);
      m_last_o[i]  = |(grant_q[i] & s_last_i);
      done[i]      = m_ready_i[i] && |(grant_q[i] & s_valid_i & s_last_i);
    end
  end
  // Sources already holding a grant are masked so a mid-packet dest change
  // can never give one source two masters.
  always_comb begin
    req = '0;
    win = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      for (int j = 0; j < S_DATA_COUNT; j++)
        req[i][j] = s_valid_i[j] && !src_busy[j] && s_dest_i[j*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(i);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = S_DATA_COUNT; k >= 1; k--)
        if (req[i][(int'(ptr_q[i]) + k) % S_DATA_COUNT])
          win[i] = T_ID___WIDTH'((int'(ptr_q[i]) + k) % S_DATA_COUNT);
`else
      for (int j = S_DATA_COUNT - 1; j >= 0; j--)
        if (req[i][j]) win[i] = T_ID___WIDTH'(j);
`endif
    end
  end
  always_comb begin
    grant_d = grant_q;
    id_d    = id_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    for (int i = 0; i < M_DATA_COUNT; i++) begin
      state_d[i] = state_q[i];
      if (state_q[i] == IDLE && |req[i]) begin
        state_d[i] = BUSY;
        grant_d[i] = S_DATA_COUNT'(1) << win[i];
        id_d[i]    = win[i];
      end else if (state_q[i] == BUSY && done[i]) begin
        state_d[i] = IDLE;
        grant_d[i] = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d[i]   = id_q[i];
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M_DATA_COUNT; i++) state_q[i] <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= {M_DATA_COUNT{T_ID___WIDTH'(S_DATA_COUNT - 1)}};
`endif
    end else begin
      for (int i = 0; i < M_DATA_COUNT; i++) state_q[i] <= state_d[i];
      grant_q <= grant_d;
      id_q    <= id_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed self-checking bench for stream_arbiter (5 sources, 3 masters)
module tb_stream_arbiter;
  logic        clk;
  logic        rst_n;
  logic [4:0]  s_valid_i;
  logic [9:0]  s_dest_i;
  logic [4:0]  s_last_i;
  logic [4:0]  s_ready_o;
  logic [2:0]  m_ready_i;
  logic [2:0]  m_valid_o;
  logic [2:0]  m_last_o;
  logic [8:0]  m_id_o;
  logic [14:0] grant_o;
  int tests = 0;
  int fails = 0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam int ALT_WIN = 3;
`else
  localparam int ALT_WIN = 0;
`endif
  stream_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_dest_i(s_dest_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_id_o(m_id_o), .grant_o(grant_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_dest(input int j, input logic [1:0] d);
    s_dest_i[j*2 +: 2] = d;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    s_valid_i = 5'b11111;
    s_last_i = 5'b0;
    s_dest_i = '0;
    m_ready_i = 3'b111;
    repeat (3) tick;
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL reset_grant got %h exp %h", grant_o, 15'h0); end
    tests++; if (s_ready_o !== 5'b0) begin fails++; $display("FAIL reset_s_ready got %b exp %b", s_ready_o, 5'b0); end
    tests++; if (m_valid_o !== 3'b0) begin fails++; $display("FAIL reset_m_valid got %b exp %b", m_valid_o, 3'b0); end
    tests++; if (m_id_o !== 9'h0) begin fails++; $display("FAIL reset_m_id got %h exp %h", m_id_o, 9'h0); end
    s_valid_i = 5'b0;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_single;
    int beats = 0;
    set_dest(2, 2'd1);
    s_valid_i = 5'b00100;
    #1;
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL single_pre_grant got %h exp %h", grant_o, 15'h0); end
    tick;
    tests++; if (grant_o !== 15'h0080) begin fails++; $display("FAIL single_grant got %h exp %h", grant_o, 15'h0080); end
    tests++; if (m_id_o[5:3] !== 3'd2) begin fails++; $display("FAIL single_id got %0d exp %0d", m_id_o[5:3], 2); end
    tests++; if (s_ready_o !== 5'b00100) begin fails++; $display("FAIL single_s_ready got %b exp %b", s_ready_o, 5'b00100); end
    for (int b = 0; b < 3; b++) begin
      s_last_i[2] = (b == 2);
      #1;
      if (m_valid_o[1] && m_ready_i[1]) beats++;
      if (b == 2) begin
        tests++; if (m_last_o !== 3'b010) begin fails++; $display("FAIL single_last got %b exp %b", m_last_o, 3'b010); end
      end
      tick;
    end
    s_valid_i = 5'b0;
    s_last_i = 5'b0;
    #1;
    tests++; if (beats !== 3) begin fails++; $display("FAIL single_beats got %0d exp %0d", beats, 3); end
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL single_cleared got %h exp %h", grant_o, 15'h0); end
    tests++; if (m_valid_o !== 3'b0) begin fails++; $display("FAIL single_m_valid_off got %b exp %b", m_valid_o, 3'b0); end
  endtask
  task automatic test_contention;
    int w;
    set_dest(0, 2'd0);
    set_dest(3, 2'd0);
    s_valid_i = 5'b01001;
    s_last_i = 5'b0;
    for (int p = 0; p < 4; p++) begin
      w = (p % 2 == 1) ? ALT_WIN : 0;
      tick;
      tests++; if (grant_o !== 15'(1) << w) begin fails++; $display("FAIL contention_grant_%0d got %h exp %h", p, grant_o, 15'(1) << w); end
      tests++; if (m_id_o[2:0] !== 3'(w)) begin fails++; $display("FAIL contention_id_%0d got %0d exp %0d", p, m_id_o[2:0], w); end
      tick;
      s_last_i[w] = 1'b1;
      tick;
      s_last_i[w] = 1'b0;
      #1;
      tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL contention_bubble_%0d got %h exp %h", p, grant_o, 15'h0); end
    end
    s_valid_i = 5'b0;
    tick;
  endtask
  task automatic test_backpressure;
    logic [8:0] rp, vp, lp;
    int beats = 0;
    rp = 9'b111100001;
    vp = 9'b110100111;
    lp = 9'b100000000;
    set_dest(1, 2'd0);
    s_valid_i = 5'b00010;
    tick;
    for (int c = 0; c < 9; c++) begin
      m_ready_i[0] = rp[c];
      s_valid_i[1] = vp[c];
      s_last_i[1] = lp[c];
      #1;
      if (m_valid_o[0] && m_ready_i[0]) beats++;
      tests++; if (grant_o !== 15'h0002) begin fails++; $display("FAIL bp_grant_held_%0d got %h exp %h", c, grant_o, 15'h0002); end
      tests++; if (s_ready_o !== {3'b0, rp[c], 1'b0}) begin fails++; $display("FAIL bp_s_ready_%0d got %b exp %b", c, s_ready_o, {3'b0, rp[c], 1'b0}); end
      tests++; if (m_valid_o[0] !== vp[c]) begin fails++; $display("FAIL bp_m_valid_%0d got %b exp %b", c, m_valid_o[0], vp[c]); end
      tick;
    end
    s_valid_i = 5'b0;
    s_last_i = 5'b0;
    m_ready_i = 3'b111;
    #1;
    tests++; if (beats !== 4) begin fails++; $display("FAIL bp_beats got %0d exp %0d", beats, 4); end
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL bp_cleared got %h exp %h", grant_o, 15'h0); end
  endtask
  task automatic test_parallel;
    set_dest(0, 2'd3);
    set_dest(1, 2'd0);
    set_dest(4, 2'd2);
    s_valid_i = 5'b10011;
    s_last_i = 5'b10000;
    tick;
    tests++; if (grant_o !== 15'h4002) begin fails++; $display("FAIL par_grant got %h exp %h", grant_o, 15'h4002); end
    tests++; if (m_id_o[2:0] !== 3'd1) begin fails++; $display("FAIL par_id0 got %0d exp %0d", m_id_o[2:0], 1); end
    tests++; if (m_id_o[8:6] !== 3'd4) begin fails++; $display("FAIL par_id2 got %0d exp %0d", m_id_o[8:6], 4); end
    tests++; if (s_ready_o !== 5'b10010) begin fails++; $display("FAIL par_s_ready got %b exp %b", s_ready_o, 5'b10010); end
    tests++; if (m_valid_o !== 3'b101) begin fails++; $display("FAIL par_m_valid got %b exp %b", m_valid_o, 3'b101); end
    tick;
    s_valid_i[4] = 1'b0;
    s_last_i = 5'b00010;
    #1;
    tests++; if (grant_o !== 15'h0002) begin fails++; $display("FAIL par_row2_done got %h exp %h", grant_o, 15'h0002); end
    tick;
    s_valid_i[1] = 1'b0;
    s_last_i = 5'b0;
    repeat (3) tick;
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL par_bad_dest_grant got %h exp %h", grant_o, 15'h0); end
    tests++; if (s_ready_o !== 5'b0) begin fails++; $display("FAIL par_bad_dest_ready got %b exp %b", s_ready_o, 5'b0); end
    s_valid_i = 5'b0;
    tick;
  endtask
  task automatic test_reset_mid_packet;
    set_dest(0, 2'd0);
    set_dest(3, 2'd0);
    s_valid_i = 5'b01000;
    s_last_i = 5'b0;
    tick;
    tests++; if (grant_o !== 15'h0008) begin fails++; $display("FAIL rmid_grant got %h exp %h", grant_o, 15'h0008); end
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    tests++; if (grant_o !== 15'h0) begin fails++; $display("FAIL rmid_async_grant got %h exp %h", grant_o, 15'h0); end
    tests++; if (m_valid_o !== 3'b0) begin fails++; $display("FAIL rmid_m_valid got %b exp %b", m_valid_o, 3'b0); end
    tests++; if (m_id_o !== 9'h0) begin fails++; $display("FAIL rmid_m_id got %h exp %h", m_id_o, 9'h0); end
    s_valid_i = 5'b01001;
    tick;
    rst_n = 1'b1;
    tick;
    tests++; if (grant_o !== 15'h0001) begin fails++; $display("FAIL rmid_first_arb got %h exp %h", grant_o, 15'h0001); end
    tests++; if (m_id_o[2:0] !== 3'd0) begin fails++; $display("FAIL rmid_first_id got %0d exp %0d", m_id_o[2:0], 0); end
    s_valid_i = 5'b0;
    tick;
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_parallel;
    test_reset_mid_packet;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
